wb_stream_fifo_fwft: RTL and testbench
======================================

Name: wb_stream_fifo_fwft

Overview:
- Parametrised single-clock stream FIFO for the wb_streamer path.
- Generalises the earlier fixed stream FIFO plus its separate FWFT adapter into one block:
  - built-in first-word-fall-through output;
  - full throughput under backpressure;
  - occupancy count, almost-full and almost-empty flags;
  - synchronous flush;
  - a sideband last bit.
- Sits between the Wishbone burst reader/writer and pixel/SD stream consumers.

Parameters:
- DW, 32, stream data width in bits (>=1).
- AW, 4, log2 of total capacity; capacity DEPTH = 2**AW words (AW>=1).
- AF_THRESH, 2**AW-2, almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous content clear, active-high.
- s_data_i  in  DW  input word.
- s_last_i  in  1  input end-of-packet marker.
- s_valid_i  in  1  input word valid.
- s_ready_o  out  1  FIFO can accept a word.
- m_data_o  out  DW  output word.
- m_last_o  out  1  last marker stored with m_data_o.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  consumer accepts the word.
- level_o  out  AW+1  words held, range 0..DEPTH.
- almost_full_o  out  1  registered threshold flag.
- almost_empty_o  out  1  registered threshold flag.

Behaviour:
- Accept: s_valid_i & s_ready_o at an edge. Consume: m_valid_o & m_ready_i at an edge.
- s_ready_o = (level_o < DEPTH). It depends on registered state only; no combinational path from m_ready_i.
- Storage: registered-read dual-port RAM plus an output stage. Together they hold exactly DEPTH words; level_o counts every held word wherever it sits.
- level_o after each edge:
  - +1 on accept only;
  - -1 on consume only;
  - unchanged on both or neither.
  - Accept while full is impossible because s_ready_o=0. Consume while empty is impossible because m_valid_o=0.
- Ordering: words leave in acceptance order, each {last,data} pair intact. No duplication or loss.
- Latency: a word accepted at edge N into an empty FIFO gives m_valid_o=1 after edge N+2 at the latest. Edge N+1 is also allowed.
- Throughput: with s_valid_i=1 and m_ready_i=1 continuously, steady state accepts and consumes one word per cycle.
- Stability: while m_valid_o=1 and m_ready_i=0, m_data_o/m_last_o hold and m_valid_o stays 1.
- Simultaneous accept and consume at level DEPTH-1 or level 1: both succeed, level unchanged.
- Wrap-around: pointers are AW bits and roll over silently. Content stays correct across any number of wraps.
- Flags: almost_full_o and almost_empty_o are computed from the next level value and registered, so they are consistent with level_o every cycle.
- rst or flush at an edge, taking priority over simultaneous accept/consume, gives:
  - level_o=0, m_valid_o=0, s_ready_o=1;
  - almost_empty_o = (AE_THRESH>=0), i.e. 1;
  - almost_full_o = (AF_THRESH==0);
  - m_data_o=0, m_last_o=0.
  - A word presented in the flush cycle is dropped.
- Reset or flush mid-burst discards all held words, including any RAM read in flight. Nothing stale appears afterwards.
- No state machine beyond output-stage occupancy. States: EMPTY, ONE (output register loaded), TWO (output plus prefetch skid loaded).
  - EMPTY->ONE: RAM read returns.
  - ONE->TWO: prefetch arrives while stalled.
  - TWO->ONE: consume.
  - ONE->EMPTY: consume with nothing pending.

Optional Feature:
- Macro: WB_STREAM_FIFO_PKT_COMMIT_EN.
- Defined:
  - Packet mode: m_valid_o is gated until at least one complete packet (a word with last=1) is held, or level_o==DEPTH (deadlock escape).
  - Internal pkt count: +1 on accept with last, -1 on consume with last; cleared by rst/flush.
  - Once a packet starts draining, its remaining words are not gated.
- Undefined:
  - m_valid_o depends on occupancy only.
  - last is plain sideband; no packet counter logic is synthesised.

Decomposition:
- Package wb_stream_pkg holds:
  - output-stage state encoding (EMPTY/ONE/TWO);
  - the level-width function clog2(DEPTH)+1;
  - the default threshold constants.
- Sub-module: wb_stream_dpram, a simple dual-port, registered-read RAM of width DW+1 and depth 2**AW. It has no bypass; read-during-write to the same address is never issued by the controller.
- The FIFO controller, output stage and flags stay in the top module.

Test Plan:
- Reset, then write 16 words 0x00..0x0F with m_ready=0 (AW=4) -> s_ready drops after the 16th, level=16, almost_full=1 from level 14. Then drain -> data 0x00..0x0F in order.
- Continuous s_valid/m_ready for 100 words -> after initial latency of 2 cycles or less, one word per cycle, level constant, data sequential with no gaps.
- Random valid/ready at 50%/50% for 10k words with wrap -> scoreboard match; m_data stable during every stall; level equals the model each cycle.
- Fill to 9, assert flush with s_valid=1 -> next cycle level=0, m_valid=0, almost_empty=1; the flushed-cycle word never emerges.
- Assert rst while level=DEPTH-1 and m_ready=1 -> all outputs return to reset values next cycle; first word written afterwards is the first word read.
- PKT_COMMIT_EN: write 3 words with last=0 -> m_valid stays 0. Write a 4th with last=1 -> m_valid=1 and 4 words drain. Fill 16 words with no last -> m_valid=1 via the full escape.

Source files
------------

// File: rtl/wb_stream_pkg.sv
// Shared types and constants for the wb_streamer stream FIFO.
package wb_stream_pkg;

   // Output-stage occupancy: nothing, output register, output register plus skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } ostate_t;

   localparam int AE_THRESH_DEF = 1;

   function automatic int af_thresh_def(input int aw);
      return (2 ** aw) - 2;
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wb_stream_dpram.sv
// Simple dual-port RAM with registered read and no write-to-read bypass.
module wb_stream_dpram #(
   parameter int W  = 33,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/wb_stream_fifo_fwft.sv
// Single-clock FWFT stream FIFO with level, almost flags, flush and last sideband.
// Define WB_STREAM_FIFO_PKT_COMMIT_EN to hold output until a whole packet is stored.
module wb_stream_fifo_fwft
   import wb_stream_pkg::*;
#(
   parameter int DW        = 32,
   parameter int AW        = 4,
   parameter int AF_THRESH = af_thresh_def(AW),
   parameter int AE_THRESH = AE_THRESH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [DW-1:0] s_data_i,
   input  logic          s_last_i,
   input  logic          s_valid_i,
   output logic          s_ready_o,
   output logic [DW-1:0] m_data_o,
   output logic          m_last_o,
   output logic          m_valid_o,
   input  logic          m_ready_i,
   output logic [AW:0]   level_o,
   output logic          almost_full_o,
   output logic          almost_empty_o
);

   localparam int DEPTH = 2 ** AW;
   localparam int LW    = level_width(DEPTH);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   ostate_t       state_q;
   logic [LW-1:0] level_q, level_d;
   logic [LW-1:0] ram_cnt_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic          rd_pend_q;
   logic [DW:0]   out_q, skid_q, ram_q;
   logic          af_q, ae_q;
   logic          accept, consume, rd_en, ost_valid;
   logic [2:0]    pipe_occ;

   // A word moves on an edge only when valid and ready are both high there.
   assign accept    = s_valid_i & s_ready_o;
   assign consume   = m_valid_o & m_ready_i;
   assign s_ready_o = (level_q < DEPTH_L);
   assign ost_valid = (state_q != ST_EMPTY);

   // Read ahead only if the output stage can still absorb the returning word.
   assign pipe_occ = {1'b0, state_q} + {2'b00, rd_pend_q};
   assign rd_en    = (ram_cnt_q != '0) && (pipe_occ <= (3'd1 + {2'b00, consume}));

   always_comb begin
      level_d = level_q;
      if (accept && !consume)      level_d = level_q + LW'(1);
      else if (!accept && consume) level_d = level_q - LW'(1);
   end

   wb_stream_dpram #(
      .W  (DW + 1),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr_q),
      .wdata ({s_last_i, s_data_i}),
      .re    (rd_en),
      .raddr (rd_ptr_q),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q   <= ST_EMPTY;
         level_q   <= '0;
         ram_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_pend_q <= 1'b0;
         out_q     <= '0;
         skid_q    <= '0;
         af_q      <= (0 >= AF_THRESH);
         ae_q      <= (0 <= AE_THRESH);
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
         ram_cnt_q <= ram_cnt_q + LW'(accept) - LW'(rd_en);
         rd_pend_q <= rd_en;
         level_q   <= level_d;
         af_q      <= (int'(level_d) >= AF_THRESH);
         ae_q      <= (int'(level_d) <= AE_THRESH);
         case (state_q)
            ST_EMPTY: begin
               if (rd_pend_q) begin
                  out_q   <= ram_q;
                  state_q <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (consume && rd_pend_q) begin
                  out_q <= ram_q;
               end else if (consume) begin
                  state_q <= ST_EMPTY;
               end else if (rd_pend_q) begin
                  skid_q  <= ram_q;
                  state_q <= ST_TWO;
               end
            end
            ST_TWO: begin
               if (consume) begin
                  out_q <= skid_q;
                  if (rd_pend_q) skid_q  <= ram_q;
                  else           state_q <= ST_ONE;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

`ifdef WB_STREAM_FIFO_PKT_COMMIT_EN
   logic [LW-1:0] pkt_cnt_q;
   logic          draining_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pkt_cnt_q  <= '0;
         draining_q <= 1'b0;
      end else begin
         pkt_cnt_q <= pkt_cnt_q + LW'(accept & s_last_i) - LW'(consume & out_q[DW]);
         if (consume) draining_q <= ~out_q[DW];
      end
   end

   // A full FIFO with no complete packet must still drain or it would deadlock.
   assign m_valid_o = ost_valid & ((pkt_cnt_q != '0) | (level_q == DEPTH_L) | draining_q);
`else
   assign m_valid_o = ost_valid;
`endif

   assign m_data_o       = out_q[DW-1:0];
   assign m_last_o       = out_q[DW];
   assign level_o        = level_q;
   assign almost_full_o  = af_q;
   assign almost_empty_o = ae_q;

endmodule

// File: tb/tb_wb_stream_fifo_fwft.sv
// Directed and random checks for wb_stream_fifo_fwft (DW=8, AW=4).
module tb_wb_stream_fifo_fwft;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [AW:0]   level;
   logic          af, ae;

   logic [DW:0]   exp_q[$];
   int            tests = 0;
   int            fails = 0;

   always #5 clk = ~clk;

   wb_stream_fifo_fwft #(
      .DW (DW),
      .AW (AW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .s_data_i       (s_data),
      .s_last_i       (s_last),
      .s_valid_i      (s_valid),
      .s_ready_o      (s_ready),
      .m_data_o       (m_data),
      .m_last_o       (m_last),
      .m_valid_o      (m_valid),
      .m_ready_i      (m_ready),
      .level_o        (level),
      .almost_full_o  (af),
      .almost_empty_o (ae)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_last = 1'b0;
      tick(); tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (level !== '0)    begin fails++; $display("FAIL reset_level got %0d want 0", level); end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
      tests++; if (ae !== 1'b1)      begin fails++; $display("FAIL reset_ae got %b want 1", ae); end
      tests++; if (af !== 1'b0)      begin fails++; $display("FAIL reset_af got %b want 0", af); end
      tests++; if (m_data !== '0)    begin fails++; $display("FAIL reset_m_data got %h want 0", m_data); end
      tests++; if (m_last !== 1'b0)  begin fails++; $display("FAIL reset_m_last got %b want 0", m_last); end
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         s_valid = 1'b1; s_data = DW'(i); s_last = 1'b0;
         tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL fill_s_ready word %0d got %b want 1", i, s_ready); end
         tick();
         tests++; if (level !== (AW+1)'(i + 1)) begin fails++; $display("FAIL fill_level got %0d want %0d", level, i + 1); end
         tests++; if (af !== (i + 1 >= AF)) begin fails++; $display("FAIL fill_af level %0d got %b want %b", i + 1, af, (i + 1 >= AF)); end
         tests++; if (ae !== (i + 1 <= AE)) begin fails++; $display("FAIL fill_ae level %0d got %b want %b", i + 1, ae, (i + 1 <= AE)); end
      end
      s_valid = 1'b0;
      tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL full_s_ready got %b want 0", s_ready); end
      tick(); tick(); tick();
      tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL full_m_valid got %b want 1", m_valid); end
      tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL full_head got %h want 00", m_data); end
      m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         for (int w = 0; w < 8 && !m_valid; w++) tick();
         tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL drain_timeout word %0d", i); end
         tests++; if (m_data !== DW'(i)) begin fails++; $display("FAIL drain_data got %h want %h", m_data, DW'(i)); end
         tick();
      end
      m_ready = 1'b0;
      tests++; if (level !== '0)   begin fails++; $display("FAIL drain_level got %0d want 0", level); end
      tests++; if (ae !== 1'b1)    begin fails++; $display("FAIL drain_ae got %b want 1", ae); end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL drain_m_valid got %b want 0", m_valid); end
   endtask

   task automatic test_back_to_back();
      int sent = 0, recv = 0, first_acc = -1;
      bit seen = 0, acc, con;
      logic [AW:0] lvl_before;
      do_reset();
      m_ready = 1'b1;
      for (int c = 0; c < 200 && recv < 100; c++) begin
         s_valid = (sent < 100); s_data = DW'(sent); s_last = 1'b1;
         acc = s_valid && s_ready;
         con = m_valid && m_ready;
         if (con) begin
            tests++; if (m_data !== DW'(recv)) begin fails++; $display("FAIL b2b_data got %h want %h", m_data, DW'(recv)); end
            recv++;
         end
         lvl_before = level;
         tick();
         if (acc) begin
            if (first_acc < 0) first_acc = c;
            sent++;
         end
         if (acc && con) begin
            tests++; if (level !== lvl_before) begin fails++; $display("FAIL b2b_level got %0d want %0d", level, lvl_before); end
         end
         if (!seen && m_valid) begin
            seen = 1;
            tests++; if (c - first_acc > 2) begin fails++; $display("FAIL b2b_latency got %0d want <=2", c - first_acc); end
         end else if (seen && recv < 100) begin
            tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL b2b_gap at word %0d got %b want 1", recv, m_valid); end
         end
      end
      s_valid = 1'b0; m_ready = 1'b0;
      tests++; if (recv != 100) begin fails++; $display("FAIL b2b_count got %0d want 100", recv); end
   endtask

   task automatic test_random();
      int sent = 0, got = 0, cyc = 0;
      bit acc, con, stall;
      logic [DW:0] held;
      do_reset();
      while (got < 10000 && cyc < 60000) begin
         s_valid = ($urandom_range(0, 1) == 1) && (sent < 10000);
         s_data  = DW'($urandom);
         s_last  = ($urandom_range(0, 1) == 1);
         m_ready = ($urandom_range(0, 1) == 1);
         tests++; if (s_ready !== (exp_q.size() < DEPTH)) begin fails++; $display("FAIL rnd_s_ready got %b want %b", s_ready, (exp_q.size() < DEPTH)); end
         acc   = s_valid && s_ready;
         con   = m_valid && m_ready;
         stall = m_valid && !m_ready;
         held  = {m_last, m_data};
         if (con) begin
            tests++;
            if (exp_q.size() == 0) begin fails++; $display("FAIL rnd_extra got %h want none", {m_last, m_data}); end
            else begin
               if ({m_last, m_data} !== exp_q[0]) begin fails++; $display("FAIL rnd_data got %h want %h", {m_last, m_data}, exp_q[0]); end
               void'(exp_q.pop_front());
            end
            got++;
         end
         if (acc) begin
            exp_q.push_back({s_last, s_data});
            sent++;
         end
         tick();
         cyc++;
         if (stall) begin
            tests++; if (m_valid !== 1'b1 || {m_last, m_data} !== held) begin
               fails++; $display("FAIL rnd_stall got %b/%h want 1/%h", m_valid, {m_last, m_data}, held);
            end
         end
         tests++; if (level !== (AW+1)'(exp_q.size())) begin fails++; $display("FAIL rnd_level got %0d want %0d", level, exp_q.size()); end
         tests++; if (af !== (exp_q.size() >= AF)) begin fails++; $display("FAIL rnd_af got %b want %b", af, (exp_q.size() >= AF)); end
         tests++; if (ae !== (exp_q.size() <= AE)) begin fails++; $display("FAIL rnd_ae got %b want %b", ae, (exp_q.size() <= AE)); end
      end
      s_valid = 1'b0; m_ready = 1'b0;
      tests++; if (got != 10000) begin fails++; $display("FAIL rnd_count got %0d want 10000", got); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         s_valid = 1'b1; s_data = DW'(8'h10 + i); s_last = 1'b0;
         tick();
      end
      tests++; if (level !== 5'd9) begin fails++; $display("FAIL flush_pre_level got %0d want 9", level); end
      s_data = 8'hAA; flush = 1'b1;
      tick();
      flush = 1'b0; s_valid = 1'b0;
      tests++; if (level !== '0)     begin fails++; $display("FAIL flush_level got %0d want 0", level); end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL flush_m_valid got %b want 0", m_valid); end
      tests++; if (ae !== 1'b1)      begin fails++; $display("FAIL flush_ae got %b want 1", ae); end
      tests++; if (af !== 1'b0)      begin fails++; $display("FAIL flush_af got %b want 0", af); end
      tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL flush_s_ready got %b want 1", s_ready); end
      tests++; if (m_data !== '0)    begin fails++; $display("FAIL flush_m_data got %h want 0", m_data); end
      tick(); tick(); tick();
      tests++; if (m_valid !== 1'b0 || level !== '0) begin fails++; $display("FAIL flush_stale got %b/%0d want 0/0", m_valid, level); end
      s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1;
      tick();
      s_valid = 1'b0; m_ready = 1'b1;
      for (int w = 0; w < 8 && !m_valid; w++) tick();
      tests++; if (m_valid !== 1'b1 || m_data !== 8'h55) begin fails++; $display("FAIL flush_next got %b/%h want 1/55", m_valid, m_data); end
      tick();
      m_ready = 1'b0;
      tests++; if (level !== '0) begin fails++; $display("FAIL flush_after_level got %0d want 0", level); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < DEPTH - 1; i++) begin
         s_valid = 1'b1; s_data = DW'(8'h80 + i); s_last = 1'b0;
         tick();
      end
      s_valid = 1'b0;
      tick(); tick(); tick();
      tests++; if (level !== 5'd15) begin fails++; $display("FAIL rmid_pre_level got %0d want 15", level); end
      m_ready = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; m_ready = 1'b0;
      tests++; if (level !== '0)     begin fails++; $display("FAIL rmid_level got %0d want 0", level); end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rmid_m_valid got %b want 0", m_valid); end
      tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rmid_s_ready got %b want 1", s_ready); end
      tests++; if (ae !== 1'b1 || af !== 1'b0) begin fails++; $display("FAIL rmid_flags got ae=%b af=%b want ae=1 af=0", ae, af); end
      tests++; if (m_data !== '0 || m_last !== 1'b0) begin fails++; $display("FAIL rmid_out got %b/%h want 0/00", m_last, m_data); end
      s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b1;
      tick();
      s_data = 8'h3D;
      tick();
      s_valid = 1'b0; m_ready = 1'b1;
      for (int w = 0; w < 8 && !m_valid; w++) tick();
      tests++; if (m_valid !== 1'b1 || m_data !== 8'h3C) begin fails++; $display("FAIL rmid_first got %b/%h want 1/3c", m_valid, m_data); end
      tick();
      for (int w = 0; w < 8 && !m_valid; w++) tick();
      tests++; if (m_valid !== 1'b1 || m_data !== 8'h3D) begin fails++; $display("FAIL rmid_second got %b/%h want 1/3d", m_valid, m_data); end
      tick();
      m_ready = 1'b0;
   endtask

`ifdef WB_STREAM_FIFO_PKT_COMMIT_EN
   task automatic test_pkt_commit();
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = DW'(8'hC0 + i); s_last = 1'b0;
         tick();
      end
      s_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL pkt_gate got %b want 0", m_valid); end
         tick();
      end
      s_valid = 1'b1; s_data = 8'hC3; s_last = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int w = 0; w < 8 && !m_valid; w++) tick();
         tests++; if (m_valid !== 1'b1 || m_data !== DW'(8'hC0 + i) || m_last !== (i == 3)) begin
            fails++; $display("FAIL pkt_drain got %b/%b/%h want 1/%b/%h", m_valid, m_last, m_data, (i == 3), DW'(8'hC0 + i));
         end
         tick();
      end
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         s_valid = 1'b1; s_data = DW'(i); s_last = 1'b0;
         tick();
      end
      s_valid = 1'b0;
      tick(); tick(); tick();
      tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL pkt_escape got %b want 1", m_valid); end
      m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         for (int w = 0; w < 8 && !m_valid; w++) tick();
         tests++; if (m_valid !== 1'b1 || m_data !== DW'(i)) begin fails++; $display("FAIL pkt_escape_data got %b/%h want 1/%h", m_valid, m_data, DW'(i)); end
         tick();
      end
      m_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_random();
      test_flush();
      test_reset_mid();
`ifdef WB_STREAM_FIFO_PKT_COMMIT_EN
      test_pkt_commit();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
